regfile_sb: RTL and testbench

Parametrised register file with integrated write-back scoreboard for the pipelined datapath.
- Generalises the fixed 32x32, two-read-port register file: width, depth, zero-register and bypass are configurable.
- Adds same-cycle write-to-read bypass, per-register busy (pending-write) tracking, and a busy-count output for the hazard/stall unit.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_sb_scoreboard.sv | 65 ++++++
 rtl/regfile_sb.sv | 79 +++++++
 tb/tb_regfile_sb.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with write-back scoreboard.
package regfile_pkg;

   localparam int unsigned DATA_W_DEFAULT = 32;
   localparam int unsigned ADDR_W_DEFAULT = 5;
   localparam int unsigned DEPTH          = 2 ** ADDR_W_DEFAULT;
   localparam logic [31:0] ZERO_ADDR      = 32'd0;

   function automatic logic is_zero_reg(input logic [31:0] addr, input logic zero_reg);
      return zero_reg && (addr == ZERO_ADDR);
   endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register pending-write tracking with a registered busy counter for the stall unit.
module regfile_sb_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [ADDR_W-1:0] rd_reg1_i,
   input  logic [ADDR_W-1:0] rd_reg2_i,
   output logic              rd_busy1_o,
   output logic              rd_busy2_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_reg_i,
   input  logic              issue_vld_i,
   input  logic [ADDR_W-1:0] issue_reg_i,
   output logic              issue_busy_o,
   output logic [ADDR_W:0]   busy_cnt_o
);

   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam logic        ZeroEn = (ZERO_REG != 0);
   localparam logic        BypEn  = (BYPASS != 0);

   logic [Depth-1:0] busy_q, busy_d, set_mask, clr_mask;
   logic [ADDR_W:0]  cnt_q, cnt_d;
   logic             rise, fall;

   // Set is applied after clear so a new producer supersedes a same-cycle write-back.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_vld_i && !is_zero_reg(32'(issue_reg_i), ZeroEn)) set_mask[issue_reg_i] = 1'b1;
      if (wr_en_i) clr_mask[wr_reg_i] = 1'b1;
      busy_d = (busy_q & ~clr_mask) | set_mask;
      rise   = |(busy_d & ~busy_q);
      fall   = |(busy_q & ~busy_d);
      cnt_d  = cnt_q + (ADDR_W + 1)'(rise) - (ADDR_W + 1)'(fall);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      rd_busy1_o = busy_q[rd_reg1_i];
      rd_busy2_o = busy_q[rd_reg2_i];
      if (is_zero_reg(32'(rd_reg1_i), ZeroEn) || (BypEn && wr_en_i && wr_reg_i == rd_reg1_i))
         rd_busy1_o = 1'b0;
      if (is_zero_reg(32'(rd_reg2_i), ZeroEn) || (BypEn && wr_en_i && wr_reg_i == rd_reg2_i))
         rd_busy2_o = 1'b0;
   end

   assign issue_busy_o = busy_q[issue_reg_i];
   assign busy_cnt_o   = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with optional zero register, write bypass and scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEFAULT,
   parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] RdReg1,
   input  logic [ADDR_W-1:0] RdReg2,
   output logic [DATA_W-1:0] RdData1,
   output logic [DATA_W-1:0] RdData2,
   output logic              RdBusy1,
   output logic              RdBusy2,
   input  logic              RegWr,
   input  logic [ADDR_W-1:0] WrReg,
   input  logic [DATA_W-1:0] WrData,
   input  logic              IssueVld,
   input  logic [ADDR_W-1:0] IssueReg,
   output logic              IssueBusy,
   output logic [ADDR_W:0]   BusyCnt
);

   localparam int unsigned Depth  = 2 ** ADDR_W;
   localparam logic        ZeroEn = (ZERO_REG != 0);
   localparam logic        BypEn  = (BYPASS != 0);

   logic [DATA_W-1:0] mem_q [Depth];
   logic [DATA_W-1:0] mem_d [Depth];
   logic              wr_live;

   assign wr_live = RegWr && !is_zero_reg(32'(WrReg), ZeroEn);

   always_comb begin
      mem_d = mem_q;
      if (wr_live) mem_d[WrReg] = WrData;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   // Zero-register forcing comes last so it overrides the bypass path.
   always_comb begin
      RdData1 = mem_q[RdReg1];
      RdData2 = mem_q[RdReg2];
      if (BypEn && wr_live && WrReg == RdReg1) RdData1 = WrData;
      if (BypEn && wr_live && WrReg == RdReg2) RdData2 = WrData;
      if (is_zero_reg(32'(RdReg1), ZeroEn)) RdData1 = '0;
      if (is_zero_reg(32'(RdReg2), ZeroEn)) RdData2 = '0;
   end

   regfile_sb_scoreboard #(
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
   ) u_scoreboard (
      .clk_i       (clk),
      .rst_ni      (reset),
      .rd_reg1_i   (RdReg1),
      .rd_reg2_i   (RdReg2),
      .rd_busy1_o  (RdBusy1),
      .rd_busy2_o  (RdBusy2),
      .wr_en_i     (RegWr),
      .wr_reg_i    (WrReg),
      .issue_vld_i (IssueVld),
      .issue_reg_i (IssueReg),
      .issue_busy_o(IssueBusy),
      .busy_cnt_o  (BusyCnt)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default, no-bypass and 16x8 configurations.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rd1, rd2, wr_reg, iss_reg;
   logic        reg_wr, iss_vld;
   logic [31:0] wr_data;
   logic [31:0] d1, d2, nb_d1, nb_d2;
   logic        b1, b2, ib, nb_b1, nb_b2, nb_ib;
   logic [5:0]  cnt, nb_cnt;

   logic [2:0]  s_rd1, s_rd2, s_wr_reg, s_iss_reg;
   logic        s_reg_wr, s_iss_vld;
   logic [15:0] s_wr_data, s_d1, s_d2;
   logic        s_b1, s_b2, s_ib;
   logic [3:0]  s_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk(clk), .reset(reset), .RdReg1(rd1), .RdReg2(rd2), .RdData1(d1), .RdData2(d2),
      .RdBusy1(b1), .RdBusy2(b2), .RegWr(reg_wr), .WrReg(wr_reg), .WrData(wr_data),
      .IssueVld(iss_vld), .IssueReg(iss_reg), .IssueBusy(ib), .BusyCnt(cnt)
   );

   regfile_sb #(.BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .RdReg1(rd1), .RdReg2(rd2), .RdData1(nb_d1), .RdData2(nb_d2),
      .RdBusy1(nb_b1), .RdBusy2(nb_b2), .RegWr(reg_wr), .WrReg(wr_reg), .WrData(wr_data),
      .IssueVld(iss_vld), .IssueReg(iss_reg), .IssueBusy(nb_ib), .BusyCnt(nb_cnt)
   );

   regfile_sb #(.DATA_W(16), .ADDR_W(3)) dut_s (
      .clk(clk), .reset(reset), .RdReg1(s_rd1), .RdReg2(s_rd2), .RdData1(s_d1), .RdData2(s_d2),
      .RdBusy1(s_b1), .RdBusy2(s_b2), .RegWr(s_reg_wr), .WrReg(s_wr_reg), .WrData(s_wr_data),
      .IssueVld(s_iss_vld), .IssueReg(s_iss_reg), .IssueBusy(s_ib), .BusyCnt(s_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      {rd1, rd2, wr_reg, iss_reg, reg_wr, iss_vld, wr_data} = '0;
      {s_rd1, s_rd2, s_wr_reg, s_iss_reg, s_reg_wr, s_iss_vld, s_wr_data} = '0;

      // 1. reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      rd1 = 5'd1; rd2 = 5'd31;
      #1;
      check("rst_rd1", d1, 0);
      check("rst_rd2", d2, 0);
      check("rst_cnt", cnt, 0);
      check("rst_busy1", b1, 0);
      check("rst_busy2", b2, 0);

      // 2. write/read and zero register
      @(negedge clk); reg_wr = 1; wr_reg = 5; wr_data = 32'hDEADBEEF;
      @(negedge clk); wr_reg = 0; wr_data = 32'h12345678;
      @(negedge clk); reg_wr = 0; rd1 = 5; rd2 = 0;
      #1;
      check("wr_r5", d1, 32'hDEADBEEF);
      check("wr_r0", d2, 0);
      check("wr_r5_nb", nb_d1, 32'hDEADBEEF);

      // 3. bypass
      @(negedge clk); reg_wr = 1; wr_reg = 7; wr_data = 32'hA5A5A5A5; rd1 = 7;
      #1;
      check("byp_data", d1, 32'hA5A5A5A5);
      check("byp_busy", b1, 0);
      check("nobyp_old", nb_d1, 0);
      @(negedge clk); reg_wr = 0;
      #1;
      check("byp_after", d1, 32'hA5A5A5A5);
      check("nobyp_after", nb_d1, 32'hA5A5A5A5);

      // 4. scoreboard basic
      @(negedge clk); iss_vld = 1; iss_reg = 3;
      @(negedge clk); iss_reg = 4;
      @(negedge clk); iss_vld = 0; rd1 = 3;
      #1;
      check("sb_cnt2", cnt, 2);
      check("sb_busy_r3", b1, 1);
      check("nobyp_busy_r3", nb_b1, 1);
      reg_wr = 1; wr_reg = 3; wr_data = 32'h33;
      #1;
      check("sb_byp_busy", b1, 0);
      check("sb_nobyp_busy", nb_b1, 1);
      @(negedge clk); reg_wr = 0;
      #1;
      check("sb_cnt1", cnt, 1);
      check("sb_r3_free", b1, 0);
      iss_vld = 1; iss_reg = 0;
      @(negedge clk); iss_vld = 0; rd1 = 0;
      #1;
      check("sb_r0_cnt", cnt, 1);
      check("sb_r0_busy", b1, 0);
      check("sb_r0_ib", ib, 0);

      // 5. simultaneous events
      iss_vld = 1; iss_reg = 9; reg_wr = 1; wr_reg = 9; wr_data = 32'h99;
      @(negedge clk); iss_vld = 0; reg_wr = 0; rd1 = 9;
      #1;
      check("sim_r9_busy", b1, 1);
      check("sim_cnt2", cnt, 2);
      iss_vld = 1; iss_reg = 10; reg_wr = 1; wr_reg = 4; wr_data = 32'h44;
      @(negedge clk); iss_vld = 0; reg_wr = 0; rd1 = 4; rd2 = 10;
      #1;
      check("sim_swap_cnt", cnt, 2);
      check("sim_r4_free", b1, 0);
      check("sim_r10_busy", b2, 1);
      iss_reg = 10;
      #1;
      check("ib_no_vld", ib, 1);
      iss_vld = 1;
      #1;
      check("waw_ib", ib, 1);
      @(negedge clk); iss_vld = 0;
      #1;
      check("waw_cnt", cnt, 2);

      // 6. reset mid-operation
      reg_wr = 1; wr_reg = 9;
      @(negedge clk); wr_reg = 10;
      @(negedge clk); reg_wr = 0;
      #1;
      check("drain_cnt", cnt, 0);
      iss_vld = 1;
      for (int i = 1; i <= 8; i++) begin
         iss_reg = 5'(i);
         @(negedge clk);
      end
      iss_vld = 0; rd1 = 5; rd2 = 8; iss_reg = 8;
      #1;
      check("full8_cnt", cnt, 8);
      check("full8_busy", b2, 1);
      #2 reset = 1'b0;
      #1;
      check("arst_cnt", cnt, 0);
      check("arst_rd1", d1, 0);
      check("arst_ib", ib, 0);
      for (int i = 1; i <= 8; i++) begin
         rd1 = 5'(i); rd2 = 5'(i);
         #1;
         check("arst_busy", b1, 0);
         check("arst_data", d2, 0);
      end
      @(negedge clk); reset = 1'b1;

      // small configuration: scenarios 2 and 4, plus count ceiling
      @(negedge clk); s_reg_wr = 1; s_wr_reg = 5; s_wr_data = 16'hBEEF;
      @(negedge clk); s_wr_reg = 0; s_wr_data = 16'h1234;
      @(negedge clk); s_reg_wr = 0; s_rd1 = 5; s_rd2 = 0;
      #1;
      check("s_wr_r5", s_d1, 16'hBEEF);
      check("s_wr_r0", s_d2, 0);
      s_iss_vld = 1; s_iss_reg = 3;
      @(negedge clk); s_iss_reg = 4;
      @(negedge clk); s_iss_vld = 0; s_rd1 = 3;
      #1;
      check("s_cnt2", s_cnt, 2);
      check("s_busy_r3", s_b1, 1);
      s_reg_wr = 1; s_wr_reg = 3;
      @(negedge clk); s_reg_wr = 0;
      #1;
      check("s_cnt1", s_cnt, 1);
      check("s_r3_free", s_b1, 0);
      s_iss_vld = 1; s_iss_reg = 0;
      @(negedge clk);
      #1;
      check("s_r0_cnt", s_cnt, 1);
      for (int i = 1; i <= 7; i++) begin
         s_iss_reg = 3'(i);
         @(negedge clk);
      end
      s_iss_reg = 0;
      @(negedge clk); s_iss_vld = 0;
      #1;
      check("s_cnt_max", s_cnt, 7);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
